laser_serial_tx_buffered: RTL and testbench



---
 rtl/laser_serial_tx_buffered.sv | 229 ++++++++++++++++++++++
 tb/tb_laser_serial_tx_buffered.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/laser_serial_tx_buffered.sv
// Laser packet serializer with a one-packet holding buffer.
// A PKT_LENGTH-bit word is sent as UART-style byte frames, most significant
// byte first and LSB first within each byte, with optional parity, one or two
// stop bits and an idle gap after every packet.
module laser_serial_tx_buffered #(
  parameter int CLK_PER_BIT = 54166,
  parameter int PKT_LENGTH  = 288,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int GAP_BITS    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PKT_LENGTH-1:0] data,
  input  logic                  new_data,
  output logic                  ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int NBYTES  = PKT_LENGTH / 8;
  localparam int TW      = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int BCW     = $clog2(NBYTES + 1);
  localparam int CNT_MAX = (GAP_BITS > 8) ? GAP_BITS : 8;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [TW-1:0]  TIMER_LAST = TW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0]  DATA_LAST  = CW'(7);
  localparam logic [CW-1:0]  STOP_LAST  = CW'(STOP_BITS - 1);
  localparam logic [CW-1:0]  GAP_LAST   = CW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [BCW-1:0] BYTE_LAST  = BCW'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
  } state_t;

  typedef enum logic [1:0] {
    SH_KEEP, SH_LOAD_DATA, SH_LOAD_HOLD, SH_NEXT_BYTE
  } shift_op_t;

  // Control registers
  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic [CW-1:0]   r_bitcnt;
  logic [BCW-1:0]  r_bytecnt;
  logic            r_hold_vld;
  logic            r_tx;
  logic            r_done;
  logic            r_ovf;

  // Data registers (no reset needed: only read while the control says valid)
  logic [PKT_LENGTH-1:0] r_shift;
  logic [PKT_LENGTH-1:0] r_hold;

  // Next-state values
  state_t          w_state_nxt;
  logic [TW-1:0]   w_timer_nxt;
  logic [CW-1:0]   w_bitcnt_nxt;
  logic [BCW-1:0]  w_bytecnt_nxt;
  logic            w_hold_vld_nxt;
  logic            w_tx_nxt;
  logic            w_done_nxt;
  logic            w_ovf_nxt;
  logic            w_hold_load;
  logic            w_pkt_end;
  shift_op_t       w_shift_op;

  logic            w_accept;
  logic            w_bit_end;
  logic [7:0]      w_cur_byte;

  // Parity bit for the byte on the wire; odd mode inverts the XOR.
  function automatic logic parity_bit(input logic [7:0] b);
    parity_bit = (PARITY_MODE == 2) ? ~(^b) : (^b);
  endfunction

  assign w_accept   = new_data && !r_hold_vld;
  assign w_bit_end  = (r_timer == TIMER_LAST);
  assign w_cur_byte = r_shift[PKT_LENGTH-1 -: 8];

  assign ready    = !r_hold_vld;
  assign tx       = r_tx;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign overflow = r_ovf;

  // Next-state, counters, buffer control and the registered value of tx.
  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = (r_state == S_IDLE || w_bit_end) ? '0 : r_timer + TW'(1);
    w_bitcnt_nxt   = r_bitcnt;
    w_bytecnt_nxt  = r_bytecnt;
    w_hold_vld_nxt = r_hold_vld;
    w_done_nxt     = 1'b0;
    w_ovf_nxt      = new_data && r_hold_vld;
    w_hold_load    = 1'b0;
    w_pkt_end      = 1'b0;
    w_shift_op     = SH_KEEP;
    w_tx_nxt       = 1'b1;

    // Accepted packet: straight to the shifter when idle, else park it.
    if (w_accept) begin
      if (r_state == S_IDLE) begin
        w_shift_op    = SH_LOAD_DATA;
        w_state_nxt   = S_START;
        w_bitcnt_nxt  = '0;
        w_bytecnt_nxt = '0;
      end else begin
        w_hold_load    = 1'b1;
        w_hold_vld_nxt = 1'b1;
      end
    end

    case (r_state)
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt  = S_DATA;
          w_bitcnt_nxt = '0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bitcnt == DATA_LAST) begin
            w_state_nxt  = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            w_bitcnt_nxt = '0;
          end else begin
            w_bitcnt_nxt = r_bitcnt + CW'(1);
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt  = S_STOP;
          w_bitcnt_nxt = '0;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_bitcnt == STOP_LAST) begin
            w_bitcnt_nxt = '0;
            if (r_bytecnt == BYTE_LAST) begin
              w_done_nxt = 1'b1;
              if (GAP_BITS == 0) w_pkt_end = 1'b1;
              else               w_state_nxt = S_GAP;
            end else begin
              w_state_nxt   = S_START;
              w_shift_op    = SH_NEXT_BYTE;
              w_bytecnt_nxt = r_bytecnt + BCW'(1);
            end
          end else begin
            w_bitcnt_nxt = r_bitcnt + CW'(1);
          end
        end
      end
      S_GAP: begin
        if (w_bit_end) begin
          if (r_bitcnt == GAP_LAST) w_pkt_end = 1'b1;
          else                      w_bitcnt_nxt = r_bitcnt + CW'(1);
        end
      end
      default: ;
    endcase

    // End of packet: drain the buffer, or take a request arriving on this
    // very edge directly so it never sits in the buffer while we go idle.
    if (w_pkt_end) begin
      w_bitcnt_nxt  = '0;
      w_bytecnt_nxt = '0;
      if (r_hold_vld) begin
        w_shift_op     = SH_LOAD_HOLD;
        w_hold_vld_nxt = 1'b0;
        w_state_nxt    = S_START;
      end else if (w_accept) begin
        w_shift_op     = SH_LOAD_DATA;
        w_hold_load    = 1'b0;
        w_hold_vld_nxt = 1'b0;
        w_state_nxt    = S_START;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end

    // The byte is stable whenever the next state is DATA or PARITY, since
    // the shifter only moves on entry to START.
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_cur_byte[w_bitcnt_nxt[2:0]];
      S_PARITY: w_tx_nxt = parity_bit(w_cur_byte);
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_bitcnt   <= '0;
      r_bytecnt  <= '0;
      r_hold_vld <= 1'b0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_bytecnt  <= w_bytecnt_nxt;
      r_hold_vld <= w_hold_vld_nxt;
      r_tx       <= w_tx_nxt;
      r_done     <= w_done_nxt;
      r_ovf      <= w_ovf_nxt;
    end
  end

  // Packet shifter and holding register.
  always_ff @(posedge clk) begin
    case (w_shift_op)
      SH_LOAD_DATA: r_shift <= data;
      SH_LOAD_HOLD: r_shift <= r_hold;
      SH_NEXT_BYTE: r_shift <= r_shift << 8;
      default:      r_shift <= r_shift;
    endcase
    if (w_hold_load) r_hold <= data;
  end

endmodule

// File: tb/tb_laser_serial_tx_buffered.sv
// Bench for laser_serial_tx_buffered: three instances cover even parity,
// odd parity and the two-stop-bit / no-gap byte configuration.
module tb_laser_serial_tx_buffered;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] d16 = '0;
  logic        nd = 1'b0;
  int          sel = 0;

  logic tx0, rdy0, busy0, done0, ovf0;
  logic tx1, rdy1, busy1, done1, ovf1;
  logic tx2, rdy2, busy2, done2, ovf2;
  logic nd0, nd1, nd2;

  assign nd0 = nd && (sel == 0);
  assign nd1 = nd && (sel == 1);
  assign nd2 = nd && (sel == 2);

  always #5 clk = ~clk;

  laser_serial_tx_buffered #(.CLK_PER_BIT(CPB), .PKT_LENGTH(16), .PARITY_MODE(1),
                             .STOP_BITS(1), .GAP_BITS(2)) u_even (
    .clk(clk), .rst_n(rst_n), .data(d16), .new_data(nd0), .ready(rdy0),
    .tx(tx0), .busy(busy0), .done(done0), .overflow(ovf0));

  laser_serial_tx_buffered #(.CLK_PER_BIT(CPB), .PKT_LENGTH(16), .PARITY_MODE(2),
                             .STOP_BITS(1), .GAP_BITS(2)) u_odd (
    .clk(clk), .rst_n(rst_n), .data(d16), .new_data(nd1), .ready(rdy1),
    .tx(tx1), .busy(busy1), .done(done1), .overflow(ovf1));

  laser_serial_tx_buffered #(.CLK_PER_BIT(CPB), .PKT_LENGTH(8), .PARITY_MODE(0),
                             .STOP_BITS(2), .GAP_BITS(0)) u_s2 (
    .clk(clk), .rst_n(rst_n), .data(d16[7:0]), .new_data(nd2), .ready(rdy2),
    .tx(tx2), .busy(busy2), .done(done2), .overflow(ovf2));

  logic m_tx, m_rdy, m_busy, m_done, m_ovf;
  always_comb begin
    m_tx = tx0; m_rdy = rdy0; m_busy = busy0; m_done = done0; m_ovf = ovf0;
    if (sel == 1) begin
      m_tx = tx1; m_rdy = rdy1; m_busy = busy1; m_done = done1; m_ovf = ovf1;
    end else if (sel == 2) begin
      m_tx = tx2; m_rdy = rdy2; m_busy = busy2; m_done = done2; m_ovf = ovf2;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int t; logic v; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int done_cnt, ovf_cnt, done_cyc, fall_cyc;
  logic busy_q = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected line value at the middle of every bit time of one packet.
  task automatic push_pkt(input logic [15:0] pkt, input int nbytes, input int pm,
                          input int sbits, input int t0);
    logic [7:0] b;
    int j;
    j = 0;
    for (int k = 0; k < nbytes; k++) begin
      b = pkt[8*(nbytes-k)-1 -: 8];
      sb.push_back('{t: t0 + CPB*j + 1, v: 1'b0}); j++;
      for (int i = 0; i < 8; i++) begin
        sb.push_back('{t: t0 + CPB*j + 1, v: b[i]}); j++;
      end
      if (pm != 0) begin
        sb.push_back('{t: t0 + CPB*j + 1, v: (pm == 2) ? ~(^b) : (^b)}); j++;
      end
      for (int s = 0; s < sbits; s++) begin
        sb.push_back('{t: t0 + CPB*j + 1, v: 1'b1}); j++;
      end
    end
  endtask

  // Scoreboard and event monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].t == cyc) begin
      check("tx_bit", m_tx, sb[0].v);
      void'(sb.pop_front());
    end
    if (m_done) begin done_cnt++; done_cyc = cyc; end
    if (m_ovf) ovf_cnt++;
    if (busy_q && !m_busy) fall_cyc = cyc;
    busy_q = m_busy;
  end

  task automatic clear_events();
    done_cnt = 0; ovf_cnt = 0; done_cyc = -1; fall_cyc = -1; busy_q = 1'b0;
  endtask

  // Present one request; returns the cycle number seen just after acceptance.
  task automatic accept(input logic [15:0] pkt, output int a);
    @(negedge clk);
    d16 = pkt; nd = 1'b1;
    @(negedge clk);
    nd = 1'b0;
    a = cyc;
  endtask

  task automatic run_single(input int s, input logic [15:0] pkt, input int nbytes,
                            input int pm, input int sbits, input int exp_done,
                            input int exp_fall);
    int a;
    sel = s;
    clear_events();
    accept(pkt, a);
    push_pkt(pkt, nbytes, pm, sbits, a);
    check("busy_on", m_busy, 1);
    check("tx_start", m_tx, 0);
    repeat (exp_fall + 10) @(negedge clk);
    check("done_cnt", done_cnt, 1);
    check("done_cyc", done_cyc - a, exp_done);
    check("busy_fall", fall_cyc - a, exp_fall);
    check("sb_empty", sb.size(), 0);
    check("ready_end", m_rdy, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    int a, bad, rdy_bad, low_late, busy_bad;

    // Reset values on all instances
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("rst_tx", m_tx, 1);
      check("rst_busy", m_busy, 0);
      check("rst_ready", m_rdy, 1);
      check("rst_done", m_done, 0);
      check("rst_ovf", m_ovf, 0);
    end
    sel = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Idle line for 100 cycles
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if ({tx0, tx1, tx2} !== 3'b111 || {busy0, busy1, busy2} !== 3'b000 ||
          {rdy0, rdy1, rdy2} !== 3'b111 || {done0, done1, done2} !== 3'b000)
        bad++;
    end
    check("idle", bad, 0);

    // Even and odd parity, then one byte with two stop bits and no gap
    run_single(0, 16'hA53C, 2, 1, 1, 88, 96);
    run_single(1, 16'hA53C, 2, 2, 1, 88, 96);
    run_single(2, 16'h00FF, 1, 0, 2, 44, 44);

    // Two queued packets and one rejected request
    sel = 0;
    clear_events();
    accept(16'hA53C, a);
    push_pkt(16'hA53C, 2, 1, 1, a);
    rdy_bad = 0; low_late = 0;
    for (int c = 1; c <= 240; c++) begin
      @(negedge clk);
      if (c == 4) begin
        check("rdy_before", m_rdy, 1);
        d16 = 16'h5AC3; nd = 1'b1;
      end
      if (c == 5) begin
        nd = 1'b0;
        push_pkt(16'h5AC3, 2, 1, 1, a + 96);
        check("rdy_full", m_rdy, 0);
        check("ovf_none", ovf_cnt, 0);
      end
      if (c == 19) begin d16 = 16'h0000; nd = 1'b1; end
      if (c == 20) nd = 1'b0;
      if (c > 5 && c < 96 && m_rdy !== 1'b0) rdy_bad++;
      if (c == 95) check("gap_tx", m_tx, 1);
      if (c == 96) begin
        check("rdy_drain", m_rdy, 1);
        check("start2_tx", m_tx, 0);
      end
      if (c > 192 && m_tx !== 1'b1) low_late++;
    end
    check("rdy_low_span", rdy_bad, 0);
    check("ovf_cnt", ovf_cnt, 1);
    check("done2_cnt", done_cnt, 2);
    check("done2_cyc", done_cyc - a, 184);
    check("busy2_fall", fall_cyc - a, 192);
    check("third_not_sent", low_late, 0);
    check("sb_empty2", sb.size(), 0);

    // Reset in the middle of the second byte with the buffer full
    clear_events();
    accept(16'hC35A, a);
    push_pkt(16'hC35A, 2, 1, 1, a);
    low_late = 0; busy_bad = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 4) begin d16 = 16'h0F0F; nd = 1'b1; end
      if (c == 5) begin nd = 1'b0; check("rdy_hold", m_rdy, 0); end
      if (c == 59) rst_n = 1'b0;
      if (c == 60) begin
        check("abort_tx", m_tx, 1);
        check("abort_busy", m_busy, 0);
        check("abort_ready", m_rdy, 1);
        sb.delete();
        rst_n = 1'b1;
      end
      if (c > 60) begin
        if (m_tx !== 1'b1) low_late++;
        if (m_busy !== 1'b0) busy_bad++;
      end
    end
    check("abort_no_start", low_late, 0);
    check("abort_no_busy", busy_bad, 0);
    check("abort_no_done", done_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
